// File: rtl/mcpu_ram_arbiter.sv
// Two-requester arbiter for the RAM controller data port; one access per ACC cycle.
// Define MCPU_RAM_ARB_RR_EN for round-robin on contention; otherwise A has fixed priority.
module mcpu_ram_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WORD_SIZE-1:0]  a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [WORD_SIZE-1:0]  a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WORD_SIZE-1:0]  b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [WORD_SIZE-1:0]  b_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_datawr,
  input  logic [WORD_SIZE-1:0]  ram_datard
);

  typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  a_done_q, a_done_d;
  logic                  b_done_q, b_done_d;
  logic [WORD_SIZE-1:0]  a_rdata_q, a_rdata_d;
  logic [WORD_SIZE-1:0]  b_rdata_q, b_rdata_d;
  logic                  a_wins;
  logic                  grant_a, grant_b;

`ifdef MCPU_RAM_ARB_RR_EN
  // last_q: 1 = B won the previous grant, so A wins the next contention
  logic last_q, last_d;
  assign a_wins = last_q;
`else
  assign a_wins = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
`ifdef MCPU_RAM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        grant_a = a_req & (~b_req | a_wins);
        grant_b = b_req & ~grant_a;
        if (grant_a) begin
          state_d = ACC_A;
          we_d    = a_we;
          addr_d  = a_addr;
          wdata_d = a_wdata;
`ifdef MCPU_RAM_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end else if (grant_b) begin
          state_d = ACC_B;
          we_d    = b_we;
          addr_d  = b_addr;
          wdata_d = b_wdata;
`ifdef MCPU_RAM_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end
      end
      ACC_A: begin
        state_d  = IDLE;
        a_done_d = 1'b1;
        if (!we_q) a_rdata_d = ram_datard;
      end
      ACC_B: begin
        state_d  = IDLE;
        b_done_d = 1'b1;
        if (!we_q) b_rdata_d = ram_datard;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef MCPU_RAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef MCPU_RAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign a_gnt      = (state_q == ACC_A);
  assign b_gnt      = (state_q == ACC_B);
  assign ram_we     = (state_q != IDLE) & we_q;
  assign ram_re     = (state_q != IDLE) & ~we_q;
  assign ram_addr   = addr_q;
  assign ram_datawr = wdata_q;
  assign a_done     = a_done_q;
  assign b_done     = b_done_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Scoreboard bench for mcpu_ram_arbiter with a behavioural RAM behind the data port.
module tb_mcpu_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_done, b_gnt, b_done;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we, ram_re;
  logic [7:0] ram_addr, ram_datawr, ram_datard;

  logic [7:0] mem [256];

  typedef struct {
    logic       is_b;
    logic [7:0] rd;
  } exp_t;

  exp_t sbq[$];
  logic gnt_log[$];
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;

  always #5 clk = ~clk;

  mcpu_ram_arbiter #(.WORD_SIZE(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_datawr(ram_datawr), .ram_datard(ram_datard)
  );

  assign ram_datard = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_datawr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: mutual exclusion every cycle, done pulses checked against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) we_cnt++;
      if (a_gnt) gnt_log.push_back(1'b0);
      if (b_gnt) gnt_log.push_back(1'b1);
      chk("gnt_mutex", {31'b0, a_gnt & b_gnt}, 32'd0);
      chk("we_re_mutex", {31'b0, ram_we & ram_re}, 32'd0);
      if (a_done || b_done) begin
        exp_t e;
        checks++;
        if (a_done && b_done) begin
          errors++;
          $display("FAIL done_both actual=1 required=0");
        end else if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=%0d required=none", b_done);
        end else begin
          e = sbq.pop_front();
          if (e.is_b !== b_done || (b_done ? b_rdata : a_rdata) !== e.rd) begin
            errors++;
            $display("FAIL done_%s actual=%0h required=%0h (requester b=%0d expected b=%0d)",
                     b_done ? "b" : "a", b_done ? b_rdata : a_rdata, e.rd, b_done, e.is_b);
          end
        end
      end
    end
  end

  task automatic access(input logic is_b, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] addr_after,
                        input logic [7:0] exp_rd);
    bit got;
    @(negedge clk);
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    sbq.push_back('{is_b, exp_rd});
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (is_b ? b_gnt : a_gnt) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout actual=0 required=1");
    end
    if (is_b) begin b_req = 0; b_addr = addr_after; b_wdata = ~wd; end
    else      begin a_req = 0; a_addr = addr_after; a_wdata = ~wd; end
  endtask

  initial begin
    logic exp_seq [4];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    reset = 1; a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_ctrl", {26'b0, a_gnt, b_gnt, a_done, b_done, ram_we, ram_re}, 32'd0);
    chk("rst_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_wdata", {24'b0, ram_datawr}, 32'd0);
    chk("rst_rdata", {16'b0, a_rdata, b_rdata}, 32'd0);

    // A write then read back; ram_we must be high exactly once
    we_cnt = 0;
    access(0, 1, 8'h10, 8'h5A, 8'h10, 8'h00);
    access(0, 0, 8'h10, 8'h00, 8'h10, 8'h5A);
    chk("we_cycles", 32'(we_cnt), 32'd1);

    // B read address changes during ACC_B: latched 0x20 wins (0x20^0xA5)
    access(1, 0, 8'h20, 8'h00, 8'h30, 8'h85);

    // A write 0xFF@0xFF then B reads it; a_rdata keeps 0x5A
    access(0, 1, 8'hFF, 8'hFF, 8'h00, 8'h5A);
    access(1, 0, 8'hFF, 8'h00, 8'h00, 8'hFF);
    @(negedge clk);
    chk("a_rdata_kept", {24'b0, a_rdata}, 32'h5A);
    chk("b_rdata_ff", {24'b0, b_rdata}, 32'hFF);

    // Continuous contention: four grants
    @(negedge clk);
    gnt_log.delete();
`ifdef MCPU_RAM_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) sbq.push_back('{exp_seq[i], exp_seq[i] ? 8'h85 : 8'h5A});
    a_req = 1; a_we = 0; a_addr = 8'h10;
    b_req = 1; b_we = 0; b_addr = 8'h20;
    repeat (7) @(negedge clk);
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    chk("cont_gnt_count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk($sformatf("cont_gnt_%0d", i), {31'b0, gnt_log[i]}, {31'b0, exp_seq[i]});

    // Reset during ACC_A: outputs clear immediately and no done follows
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h10;
    @(negedge clk);
    chk("pre_rst_gnt", {31'b0, a_gnt}, 32'd1);
    reset = 1;
    #1;
    chk("mid_rst_ctrl", {26'b0, a_gnt, b_gnt, a_done, b_done, ram_we, ram_re}, 32'd0);
    chk("mid_rst_addr", {24'b0, ram_addr}, 32'd0);
    chk("mid_rst_rdata", {16'b0, a_rdata, b_rdata}, 32'd0);
    a_req = 0;
    #1 reset = 0;
    repeat (4) @(negedge clk);

    // First contention after reset goes to A
    sbq.push_back('{1'b0, 8'h5A});
    a_req = 1; a_addr = 8'h10; b_req = 1; b_addr = 8'h20;
    @(negedge clk);
    chk("post_rst_gnt", {30'b0, a_gnt, b_gnt}, 32'b10);
    a_req = 0; b_req = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
